// File: rtl/pattern_vg_pkg.sv
// Shared definitions for the pattern_vg_ext test-pattern generator.
//   - Pattern code constants (codes 8..255 behave as passthrough).
//   - Colour-bar table: {r,g,b} component enables, bar 0 first.
//   - pix_max(): all-ones value of a colour channel of a given width.
package pattern_vg_pkg;

    localparam logic [7:0] PAT_PASS    = 8'd0;
    localparam logic [7:0] PAT_BORDER  = 8'd1;
    localparam logic [7:0] PAT_MOIRE_X = 8'd2;
    localparam logic [7:0] PAT_MOIRE_Y = 8'd3;
    localparam logic [7:0] PAT_HRAMP   = 8'd4;
    localparam logic [7:0] PAT_VRAMP   = 8'd5;
    localparam logic [7:0] PAT_BARS    = 8'd6;
    localparam logic [7:0] PAT_CHECK   = 8'd7;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [0:7][2:0] BAR_RGB = {3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};

    function automatic int unsigned pix_max(input int unsigned bits);
        return (bits >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    endfunction

endpackage

// File: rtl/pattern_vg_ramp_acc.sv
// Fixed-point ramp accumulator.
//   clk_in, reset : pixel clock, async active-low reset
//   load/load_val : current pixel sees load_val instead of the stored value
//   clr           : current pixel sees 0 (takes priority over load)
//   add           : store current value + step for the next pixel
//   step          : increment, ACC_W bits with FRAC_W fractional bits
//   level         : integer part of the value for the current pixel
// The accumulator wraps modulo 2^ACC_W; no saturation.
module pattern_vg_ramp_acc #(
    parameter int ACC_W  = 20,
    parameter int FRAC_W = 12
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     load,
    input  logic [ACC_W-1:0]         load_val,
    input  logic                     clr,
    input  logic                     add,
    input  logic [ACC_W-1:0]         step,
    output logic [ACC_W-FRAC_W-1:0]  level
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] val;

    // Load/clear act on the pixel being presented, so the first pixel of a
    // line (or frame) already sees the restarted ramp.
    always_comb begin
        if (clr)       val = '0;
        else if (load) val = load_val;
        else           val = acc_q;
    end

    assign level = val[ACC_W-1:FRAC_W];

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)   acc_q <= '0;
        else if (add) acc_q <= val + step;
        else          acc_q <= val;
    end

endmodule

// File: rtl/pattern_vg_ext.sv
// Second-generation video test-pattern generator, fixed 2-cycle pipeline.
//   clk_in, reset                  : pixel clock, async active-low reset
//   x, y, vn_in, hn_in, dn_in      : raster position and syncs/data enable
//   r_in, g_in, b_in               : upstream pixel
//   total_active_pix/lines         : active raster size
//   pattern                        : requested code, latched at frame start
//   ramp_step, ramp_mask           : ramp increment and {r,g,b} enables
//   check_log2, anim_en            : checker square size, scroll enable
//   vn_out, hn_out, den_out        : syncs delayed by 2
//   r_out, g_out, b_out            : generated pixel
//   pattern_cur                    : code in effect for the output pixel
// Stage 1 registers inputs plus per-pixel flags, ramp levels and bar index;
// stage 2 selects the colour.
module pattern_vg_ext
    import pattern_vg_pkg::*;
#(
    parameter int B               = 8,
    parameter int X_BITS          = 13,
    parameter int Y_BITS          = 13,
    parameter int FRACTIONAL_BITS = 12,
    parameter int FRAME_CNT_BITS  = 8
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic [X_BITS-1:0]            x,
    input  logic [Y_BITS-1:0]            y,
    input  logic                         vn_in,
    input  logic                         hn_in,
    input  logic                         dn_in,
    input  logic [B-1:0]                 r_in,
    input  logic [B-1:0]                 g_in,
    input  logic [B-1:0]                 b_in,
    input  logic [X_BITS-1:0]            total_active_pix,
    input  logic [Y_BITS-1:0]            total_active_lines,
    input  logic [7:0]                   pattern,
    input  logic [B+FRACTIONAL_BITS-1:0] ramp_step,
    input  logic [2:0]                   ramp_mask,
    input  logic [3:0]                   check_log2,
    input  logic                         anim_en,
    output logic                         vn_out,
    output logic                         hn_out,
    output logic                         den_out,
    output logic [B-1:0]                 r_out,
    output logic [B-1:0]                 g_out,
    output logic [B-1:0]                 b_out,
    output logic [7:0]                   pattern_cur
);

    localparam int STAGES = 2;
    localparam int ACC_W  = B + FRACTIONAL_BITS;
    localparam int CW     = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
    localparam logic [B-1:0] MAXV = B'(pix_max(B));

    typedef struct packed {
        logic [7:0]   pat;
        logic [B-1:0] r;
        logic [B-1:0] g;
        logic [B-1:0] b;
        logic         border;
        logic         mx;
        logic         my;
        logic         chk;
        logic [B-1:0] hval;
        logic [B-1:0] vval;
        logic [2:0]   bar;
        logic [2:0]   mask;
    } s1_t;

    // {vn, hn, dn} per stage
    logic [STAGES:1][2:0] sync_pipe;

    logic                      frame_start;
    logic [7:0]                pattern_q, pat_eff;
    logic [FRAME_CNT_BITS-1:0] frame_cnt_q, frame_cnt;
    logic                      last_pix, last_line;
    logic [B-1:0]              hval, vval;
    logic [X_BITS-1:0]         xs;
    logic                      chk;
    logic [X_BITS-1:0]         bw;
    logic [X_BITS-1:0]         bar_pos_q, bar_pos_cur, bar_pos_nxt;
    logic [2:0]                bar_idx_q, bar_idx_cur, bar_idx_nxt, bar_sel;
    s1_t                       s1_d, s1_q;
    logic [B-1:0]              r_d, g_d, b_d;
    logic [2:0]                bar_rgb;

    // ---------------------------------------------------------------- stage 1
    assign frame_start = dn_in && (x == '0) && (y == '0);
    assign pat_eff     = frame_start ? pattern : pattern_q;
    // The counter advances on the frame-start pixel itself so the whole frame
    // scrolls by one consistent offset.
    assign frame_cnt   = frame_start ? frame_cnt_q + FRAME_CNT_BITS'(1) : frame_cnt_q;
    assign last_pix    = (x == total_active_pix - X_BITS'(1));
    assign last_line   = (y == total_active_lines - Y_BITS'(1));

    pattern_vg_ramp_acc #(.ACC_W(ACC_W), .FRAC_W(FRACTIONAL_BITS)) u_hacc (
        .clk_in   (clk_in),
        .reset    (reset),
        .load     (x == '0),
        .load_val ('0),
        .clr      (1'b0),
        .add      (dn_in),
        .step     (ramp_step),
        .level    (hval)
    );

    pattern_vg_ramp_acc #(.ACC_W(ACC_W), .FRAC_W(FRACTIONAL_BITS)) u_vacc (
        .clk_in   (clk_in),
        .reset    (reset),
        .load     (1'b0),
        .load_val ('0),
        .clr      (frame_start),
        .add      (dn_in && last_pix),
        .step     (ramp_step),
        .level    (vval)
    );

    // Checker bit: bit check_log2 of (xs XOR y), out-of-range sizes give 0.
    assign xs  = x + (anim_en ? X_BITS'(frame_cnt) : X_BITS'(0));
    assign chk = |((CW'(xs) ^ CW'(y)) & (CW'(1) << check_log2));

    // Colour bars: position counter within the current bar plus a saturating
    // bar index, both restarting at x==0. Avoids a divider.
    assign bw          = total_active_pix >> 3;
    assign bar_pos_cur = (x == '0) ? '0 : bar_pos_q;
    assign bar_idx_cur = (x == '0) ? 3'd0 : bar_idx_q;
    assign bar_sel     = (bw == '0) ? 3'd7 : bar_idx_cur;

    always_comb begin
        bar_pos_nxt = bar_pos_cur;
        bar_idx_nxt = bar_idx_cur;
        if (dn_in) begin
            if (bar_pos_cur == bw - X_BITS'(1)) begin
                bar_pos_nxt = '0;
                if (bar_idx_cur != 3'd7) bar_idx_nxt = bar_idx_cur + 3'd1;
            end else begin
                bar_pos_nxt = bar_pos_cur + X_BITS'(1);
            end
        end
    end

    always_comb begin
        s1_d        = '0;
        s1_d.pat    = pat_eff;
        s1_d.r      = r_in;
        s1_d.g      = g_in;
        s1_d.b      = b_in;
        s1_d.border = (x == '0) || (y == '0) || last_pix || last_line;
        s1_d.mx     = x[0];
        s1_d.my     = y[0];
        s1_d.chk    = chk;
        s1_d.hval   = hval;
        s1_d.vval   = vval;
        s1_d.bar    = bar_sel;
        s1_d.mask   = ramp_mask;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pattern_q   <= '0;
            frame_cnt_q <= '0;
            bar_pos_q   <= '0;
            bar_idx_q   <= '0;
            s1_q        <= '0;
            sync_pipe   <= '0;
        end else begin
            if (frame_start) pattern_q <= pattern;
            frame_cnt_q  <= frame_cnt;
            bar_pos_q    <= bar_pos_nxt;
            bar_idx_q    <= bar_idx_nxt;
            s1_q         <= s1_d;
            sync_pipe[1] <= {vn_in, hn_in, dn_in};
            for (int i = 2; i <= STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
        end
    end

    // ---------------------------------------------------------------- stage 2
    always_comb begin
        bar_rgb = BAR_RGB[s1_q.bar];
        r_d = s1_q.r;
        g_d = s1_q.g;
        b_d = s1_q.b;
        case (s1_q.pat)
            PAT_BORDER: begin
                if (s1_q.border) begin
                    r_d = MAXV; g_d = MAXV; b_d = MAXV;
                end
            end
            PAT_MOIRE_X: begin
                r_d = s1_q.mx ? MAXV : '0;
                g_d = s1_q.mx ? MAXV : '0;
                b_d = s1_q.mx ? MAXV : '0;
            end
            PAT_MOIRE_Y: begin
                r_d = s1_q.my ? MAXV : '0;
                g_d = s1_q.my ? MAXV : '0;
                b_d = s1_q.my ? MAXV : '0;
            end
            PAT_HRAMP: begin
                r_d = s1_q.mask[2] ? s1_q.hval : '0;
                g_d = s1_q.mask[1] ? s1_q.hval : '0;
                b_d = s1_q.mask[0] ? s1_q.hval : '0;
            end
            PAT_VRAMP: begin
                r_d = s1_q.mask[2] ? s1_q.vval : '0;
                g_d = s1_q.mask[1] ? s1_q.vval : '0;
                b_d = s1_q.mask[0] ? s1_q.vval : '0;
            end
            PAT_BARS: begin
                r_d = bar_rgb[2] ? MAXV : '0;
                g_d = bar_rgb[1] ? MAXV : '0;
                b_d = bar_rgb[0] ? MAXV : '0;
            end
            PAT_CHECK: begin
                r_d = s1_q.chk ? MAXV : '0;
                g_d = s1_q.chk ? MAXV : '0;
                b_d = s1_q.chk ? MAXV : '0;
            end
            default: ;
        endcase
        // Only pure passthrough forwards blanking-interval data.
        if (!sync_pipe[1][0] && (s1_q.pat != PAT_PASS)) begin
            r_d = '0; g_d = '0; b_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_out       <= '0;
            g_out       <= '0;
            b_out       <= '0;
            pattern_cur <= '0;
        end else begin
            r_out       <= r_d;
            g_out       <= g_d;
            b_out       <= b_d;
            pattern_cur <= s1_q.pat;
        end
    end

    assign {vn_out, hn_out, den_out} = sync_pipe[STAGES];

endmodule

// File: tb/tb_pattern_vg_ext.sv
module tb_pattern_vg_ext;

    localparam int B   = 8;
    localparam int XB  = 13;
    localparam int YB  = 13;
    localparam int FB  = 12;

    logic            clk_in = 1'b0;
    logic            reset  = 1'b0;
    logic [XB-1:0]   x = '0;
    logic [YB-1:0]   y = '0;
    logic            vn_in = 1'b0, hn_in = 1'b0, dn_in = 1'b0;
    logic [B-1:0]    r_in = '0, g_in = '0, b_in = '0;
    logic [XB-1:0]   total_active_pix = XB'(16);
    logic [YB-1:0]   total_active_lines = YB'(8);
    logic [7:0]      pattern = '0;
    logic [B+FB-1:0] ramp_step = '0;
    logic [2:0]      ramp_mask = 3'b111;
    logic [3:0]      check_log2 = '0;
    logic            anim_en = 1'b0;
    logic            vn_out, hn_out, den_out;
    logic [B-1:0]    r_out, g_out, b_out;
    logic [7:0]      pattern_cur;

    pattern_vg_ext dut (
        .clk_in(clk_in), .reset(reset), .x(x), .y(y),
        .vn_in(vn_in), .hn_in(hn_in), .dn_in(dn_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .total_active_pix(total_active_pix), .total_active_lines(total_active_lines),
        .pattern(pattern), .ramp_step(ramp_step), .ramp_mask(ramp_mask),
        .check_log2(check_log2), .anim_en(anim_en),
        .vn_out(vn_out), .hn_out(hn_out), .den_out(den_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .pattern_cur(pattern_cur)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: latched pattern and frames seen since reset.
    int m_pat_q  = 0;
    int m_frames = 0;
    logic [2:0] bars [8];

    typedef struct { logic [34:0] v; int x; int y; } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {vn,hn,dn,r,g,b,pattern_cur} for the pixel currently driven.
    function automatic logic [34:0] model_pix();
        logic [7:0] r, g, b;
        int pat, xi, yi, tap, nl, bw, idx, xs;
        longint hv, vv;
        bit on;
        xi  = int'(x);
        yi  = int'(y);
        tap = int'(total_active_pix);
        nl  = int'(total_active_lines);
        if (dn_in && xi == 0 && yi == 0) begin
            m_pat_q  = int'(pattern);
            m_frames = (m_frames + 1) % 256;
        end
        pat = m_pat_q;
        r = r_in; g = g_in; b = b_in;
        hv = ((longint'(xi) * longint'(ramp_step)) >> FB) % 256;
        vv = ((longint'(yi) * longint'(ramp_step)) >> FB) % 256;
        case (pat)
            1: if (xi == 0 || yi == 0 || xi == tap - 1 || yi == nl - 1) begin
                   r = 8'hFF; g = 8'hFF; b = 8'hFF;
               end
            2: begin on = (xi % 2) == 1; r = on ? 8'hFF : 8'h00; g = r; b = r; end
            3: begin on = (yi % 2) == 1; r = on ? 8'hFF : 8'h00; g = r; b = r; end
            4: begin
                r = ramp_mask[2] ? 8'(hv) : 8'h00;
                g = ramp_mask[1] ? 8'(hv) : 8'h00;
                b = ramp_mask[0] ? 8'(hv) : 8'h00;
            end
            5: begin
                r = ramp_mask[2] ? 8'(vv) : 8'h00;
                g = ramp_mask[1] ? 8'(vv) : 8'h00;
                b = ramp_mask[0] ? 8'(vv) : 8'h00;
            end
            6: begin
                bw  = tap / 8;
                idx = (bw == 0) ? 7 : ((xi / bw > 7) ? 7 : xi / bw);
                r = bars[idx][2] ? 8'hFF : 8'h00;
                g = bars[idx][1] ? 8'hFF : 8'h00;
                b = bars[idx][0] ? 8'hFF : 8'h00;
            end
            7: begin
                xs = (xi + (anim_en ? m_frames : 0)) % 8192;
                on = (((xs >> check_log2) ^ (yi >> check_log2)) & 1) == 1;
                r = on ? 8'hFF : 8'h00; g = r; b = r;
            end
            default: ;
        endcase
        if (pat != 0 && !dn_in) begin r = 8'h00; g = 8'h00; b = 8'h00; end
        return {vn_in, hn_in, dn_in, r, g, b, 8'(pat)};
    endfunction

    // Drive one pixel, advance one clock, compare the pixel from 2 cycles ago.
    task automatic pix(input int xi, input int yi, input bit dn, input bit hn, input bit vn);
        exp_t e, o;
        x = XB'(xi); y = YB'(yi);
        dn_in = dn; hn_in = hn; vn_in = vn;
        r_in = B'($urandom); g_in = B'($urandom); b_in = B'($urandom);
        e.v = model_pix(); e.x = xi; e.y = yi;
        exp_q.push_back(e);
        @(posedge clk_in); #1;
        o = exp_q.pop_front();
        check($sformatf("pix(%0d,%0d)", o.x, o.y),
              {29'd0, vn_out, hn_out, den_out, r_out, g_out, b_out, pattern_cur}, {29'd0, o.v});
    endtask

    task automatic frame(input int tap, input int nlines, input int pat_a,
                         input int pat_b, input int sw_y);
        pattern = 8'(pat_a);
        for (int yy = 0; yy < nlines; yy++) begin
            if (yy == sw_y) pattern = 8'(pat_b);
            for (int xx = 0; xx < tap; xx++) pix(xx, yy, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) pix($urandom_range(0, 8191), yy, 1'b0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 4; k++)
            pix($urandom_range(0, 8191), $urandom_range(0, 8191), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic model_reset();
        exp_t z;
        m_pat_q = 0; m_frames = 0;
        exp_q.delete();
        z.v = '0; z.x = -1; z.y = -1;
        exp_q.push_back(z);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_r"},   64'(r_out), 64'd0);
        check({tag, "_g"},   64'(g_out), 64'd0);
        check({tag, "_b"},   64'(b_out), 64'd0);
        check({tag, "_vn"},  64'(vn_out), 64'd0);
        check({tag, "_hn"},  64'(hn_out), 64'd0);
        check({tag, "_den"}, 64'(den_out), 64'd0);
        check({tag, "_pc"},  64'(pattern_cur), 64'd0);
    endtask

    initial begin
        int pats [12];
        int tap, nl, pa, pb, sw;
        bars[0] = 3'b111; bars[1] = 3'b110; bars[2] = 3'b011; bars[3] = 3'b010;
        bars[4] = 3'b101; bars[5] = 3'b100; bars[6] = 3'b001; bars[7] = 3'b000;
        pats = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 200, 255};

        // Power-on reset
        #3;
        check_outputs_zero("por");
        @(posedge clk_in); #1;
        reset = 1'b1;
        model_reset();

        // Horizontal ramp on a 1920x1080 raster (one line scanned), full mask
        total_active_pix = XB'(1920); total_active_lines = YB'(1080);
        ramp_step = 20'h00880; ramp_mask = 3'b111;
        frame(1920, 1, 4, 4, -1);
        ramp_mask = 3'b100;
        frame(1920, 1, 4, 4, -1);

        // Colour bars, 240-pixel bars, then a width too small for any bar
        ramp_mask = 3'b111;
        frame(1920, 1, 6, 6, -1);
        total_active_pix = XB'(5); total_active_lines = YB'(4);
        frame(5, 2, 6, 6, -1);

        // Animated checkerboard over enough frames for the count to pass 8
        total_active_pix = XB'(16); total_active_lines = YB'(4);
        check_log2 = 4'd3; anim_en = 1'b1;
        for (int f = 0; f < 10; f++) frame(16, 1, 7, 7, -1);
        anim_en = 1'b0;
        frame(16, 2, 7, 7, -1);

        // Border switched to moire X mid-frame: takes effect next frame only
        total_active_pix = XB'(8); total_active_lines = YB'(600);
        frame(8, 600, 1, 2, 500);
        frame(8, 2, 2, 2, -1);

        // Vertical ramp, one level per line, wraps at 256; cleared next frame
        total_active_pix = XB'(4); total_active_lines = YB'(300);
        ramp_step = 20'h01000;
        frame(4, 300, 5, 5, -1);
        frame(4, 3, 5, 5, -1);

        // Randomised frames
        for (int f = 0; f < 30; f++) begin
            tap = $urandom_range(1, 40);
            nl  = $urandom_range(1, 12);
            total_active_pix   = XB'(tap);
            total_active_lines = YB'(nl + $urandom_range(0, 1));
            ramp_step  = 20'($urandom);
            ramp_mask  = 3'($urandom);
            check_log2 = ($urandom_range(0, 7) == 0) ? 4'd11 : 4'($urandom_range(0, 4));
            anim_en    = 1'($urandom);
            pa = pats[$urandom_range(0, 11)];
            pb = pats[$urandom_range(0, 11)];
            sw = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nl - 1) : -1;
            frame(tap, nl, pa, pb, sw);
        end

        // Reset mid-frame while the border pattern drives MAX on line 0
        total_active_pix = XB'(12); total_active_lines = YB'(6);
        pattern = 8'd1;
        for (int xx = 0; xx < 6; xx++) pix(xx, 0, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0; dn_in = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        @(posedge clk_in); #1;
        reset = 1'b1;
        model_reset();
        // Before the next frame start the latched code is 0 (passthrough)
        pattern = 8'd3;
        pix(5, 3, 1'b1, 1'b0, 1'b0);
        pix(6, 3, 1'b1, 1'b0, 1'b0);
        pix(0, 0, 1'b0, 1'b0, 1'b1);
        pix(3, 2, 1'b0, 1'b1, 1'b0);
        frame(12, 6, 3, 3, -1);
        frame(12, 2, 3, 3, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
